hamming_secded_decoder: RTL and testbench

Parametrised, pipelined Hamming SECDED decoder. It is the successor to the fixed [7,4] decoder: data width is generic, an overall parity bit is added, and double errors are detected.
- Sits between a storage or link receive path and the consumer. Valid/ready handshake on both sides.
- Corrects single-bit errors and flags double-bit errors.
- Keeps saturating counts of corrected and uncorrectable words.

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_secded_decoder_syndrome.sv | 21 ++
 rtl/hamming_secded_decoder.sv | 150 +++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED decoder and encoder: width math,
// check-bit position tests, data-position map and syndrome column masks.
package hamming_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_CORR, ERR_UNCORR} err_class_e;

  // Largest codeword supported: DATA_W=57 gives 57+6+1.
  localparam int MAX_CODE_W = 64;

  function automatic int calc_parity_w(input int data_w);
    int r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int idx);
    return (idx > 0) && ((idx & (idx - 1)) == 0);
  endfunction

  // Code position of data bit data_idx: the (data_idx+1)-th non-power-of-two position >= 3.
  function automatic int data_pos(input int data_idx);
    int pos  = 2;
    int seen = -1;
    while (seen < data_idx) begin
      pos++;
      if (!is_pow2(pos)) seen++;
    end
    return pos;
  endfunction

  // Positions whose index has bit bit_idx set; syndrome bit j is the parity over them.
  function automatic logic [MAX_CODE_W-1:0] syn_mask(input int bit_idx);
    logic [MAX_CODE_W-1:0] m = '0;
    for (int i = 1; i < MAX_CODE_W; i++) begin
      if (((i >> bit_idx) & 1) == 1) m = m | (MAX_CODE_W'(1) << i);
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational syndrome and overall-parity generator, shared between the
// decoder and the encoder's self-checker.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int CODE_W   = 8,
  parameter int PARITY_W = 3
) (
  input  logic [CODE_W-1:0]   i_code,
  output logic [PARITY_W-1:0] o_syndrome,
  output logic                o_parity
);

  for (genvar j = 0; j < PARITY_W; j++) begin : g_syn
    localparam logic [MAX_CODE_W-1:0] MASK = syn_mask(j);
    assign o_syndrome[j] = ^(i_code & MASK[CODE_W-1:0]);
  end

  assign o_parity = ^i_code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready on both sides and
// saturating error counters. Define HAMMING_ERR_INJECT_EN to add the inj_mask port.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter  int DATA_W   = 4,
  parameter  int CNT_W    = 16,
  localparam int PARITY_W = calc_parity_w(DATA_W),
  localparam int CODE_W   = DATA_W + PARITY_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [CODE_W-1:0]   inj_mask,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [PARITY_W-1:0] out_syndrome,
  output logic                out_corr,
  output logic                out_uncorr,
  output logic [CNT_W-1:0]    corr_cnt,
  output logic [CNT_W-1:0]    uncorr_cnt,
  input  logic                cnt_clr
);

  localparam logic [PARITY_W:0] CODE_W_L = (PARITY_W + 1)'(CODE_W);

  logic [CODE_W-1:0]   w_code;
  logic [PARITY_W-1:0] w_syn;
  logic                w_par;
  logic [DATA_W-1:0]   w_raw_data;
  logic [DATA_W-1:0]   w_fixed_data;
  logic [PARITY_W:0]   w_syn_ext;
  err_class_e          w_class;
  logic                w_out_fire;
  logic                w_s2_free;
  logic                w_s1_free;

  logic                r_s1_valid;
  logic [DATA_W-1:0]   r_s1_data;
  logic [PARITY_W-1:0] r_s1_syn;
  logic                r_s1_par;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [PARITY_W-1:0] r_out_syn;
  logic                r_out_corr;
  logic                r_out_uncorr;
  logic [CNT_W-1:0]    r_corr_cnt;
  logic [CNT_W-1:0]    r_uncorr_cnt;

`ifdef HAMMING_ERR_INJECT_EN
  assign w_code = in_code ^ inj_mask;
`else
  assign w_code = in_code;
`endif

  hamming_syndrome #(
    .CODE_W   (CODE_W),
    .PARITY_W (PARITY_W)
  ) u_syndrome (
    .i_code     (w_code),
    .o_syndrome (w_syn),
    .o_parity   (w_par)
  );

  // Check bits are fully consumed by the syndrome, so stage 1 keeps only the data field.
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int                  POS   = data_pos(k);
    localparam logic [PARITY_W-1:0] POS_S = PARITY_W'(POS);
    assign w_raw_data[k]   = w_code[POS];
    assign w_fixed_data[k] = r_s1_data[k] ^ ((w_class == ERR_CORR) && (r_s1_syn == POS_S));
  end

  assign w_out_fire = r_out_valid && out_ready;
  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_s1_free  = !r_s1_valid || w_s2_free;
  assign in_ready   = rst_n && w_s1_free;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_s1_free) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_raw_data;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
    end
  end

  assign w_syn_ext = {1'b0, r_s1_syn};

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_class = ERR_NONE;
    if (r_s1_par) begin
      w_class = (w_syn_ext < CODE_W_L) ? ERR_CORR : ERR_UNCORR;
    end else if (r_s1_syn != '0) begin
      w_class = ERR_UNCORR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_syn    <= '0;
      r_out_corr   <= 1'b0;
      r_out_uncorr <= 1'b0;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data   <= w_fixed_data;
        r_out_syn    <= r_s1_syn;
        r_out_corr   <= (w_class == ERR_CORR);
        r_out_uncorr <= (w_class == ERR_UNCORR);
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_out_corr && (r_corr_cnt != '1))     r_corr_cnt   <= r_corr_cnt + 1'b1;
      if (r_out_uncorr && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_syndrome = r_out_syn;
  assign out_corr     = r_out_corr;
  assign out_uncorr   = r_out_uncorr;
  assign corr_cnt     = r_corr_cnt;
  assign uncorr_cnt   = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder (DATA_W=4, CNT_W=2): directed
// steps followed by randomized traffic against a behavioural SECDED model.
module tb_hamming_secded_decoder;

  localparam int DATA_W   = 4;
  localparam int PARITY_W = 3;
  localparam int CODE_W   = 8;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [PARITY_W-1:0] out_syndrome;
  logic                out_corr;
  logic                out_uncorr;
  logic [CNT_W-1:0]    corr_cnt;
  logic [CNT_W-1:0]    uncorr_cnt;
  logic                cnt_clr;
`ifdef HAMMING_ERR_INJECT_EN
  logic [CODE_W-1:0]   inj_mask = '0;
`endif

  always #5 clk = ~clk;

  hamming_secded_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_mask     (inj_mask),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_corr     (out_corr),
    .out_uncorr   (out_uncorr),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt),
    .cnt_clr      (cnt_clr)
  );

  typedef struct {
    logic [DATA_W-1:0]   data;
    logic [PARITY_W-1:0] syn;
    logic                corr;
    logic                uncorr;
  } exp_t;

  typedef struct {
    logic                valid;
    logic                rdy;
    logic [DATA_W-1:0]   data;
    logic [PARITY_W-1:0] syn;
    logic                corr;
    logic                uncorr;
  } obs_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_corr   = 0;
  int   m_uncorr = 0;
  int   n_fired  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Place data in non-power-of-two slots, then pick check bits so the syndrome is zero.
  function automatic logic [CODE_W-1:0] model_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] c = '0;
    int s = 0;
    int k = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (((data >> k) & 1) != 0) begin
          c = c | (CODE_W'(1) << p);
          s ^= p;
        end
        k++;
      end
    end
    for (int j = 0; j < PARITY_W; j++)
      if (((s >> j) & 1) != 0) c = c | (CODE_W'(1) << (1 << j));
    if (^c) c = c | CODE_W'(1);
    return c;
  endfunction

  function automatic exp_t model_decode(input logic [CODE_W-1:0] code);
    exp_t e;
    logic [CODE_W-1:0] fixed;
    int s = 0;
    int p = 0;
    int k = 0;
    for (int i = 0; i < CODE_W; i++)
      if (((code >> i) & 1) != 0) begin
        p ^= 1;
        s ^= i;
      end
    e.corr   = (p == 1) && (s <= CODE_W - 1);
    e.uncorr = ((p == 1) && (s > CODE_W - 1)) || ((p == 0) && (s != 0));
    fixed    = e.corr ? (code ^ (CODE_W'(1) << s)) : code;
    e.data   = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if ((pos & (pos - 1)) != 0) begin
        if (((fixed >> pos) & 1) != 0) e.data = e.data | (DATA_W'(1) << k);
        k++;
      end
    e.syn = PARITY_W'(s);
    return e;
  endfunction

  // One clock: drive inputs, sample off-edge, compare, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [CODE_W-1:0] code, input logic ordy,
                       input logic clr, output obs_t o);
    logic acc;
    logic fire;
    exp_t e;
    in_valid  = v;
    in_code   = code;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    o.valid = out_valid;
    o.rdy   = in_ready;
    o.data  = out_data;
    o.syn   = out_syndrome;
    o.corr  = out_corr;
    o.uncorr = out_uncorr;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(out_valid), 0);
      end else begin
        e = sb[0];
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
        check("out_corr", 32'(out_corr), 32'(e.corr));
        check("out_uncorr", 32'(out_uncorr), 32'(e.uncorr));
      end
    end
    check("corr_cnt", 32'(corr_cnt), m_corr);
    check("uncorr_cnt", 32'(uncorr_cnt), m_uncorr);
    @(posedge clk);
    if (fire && sb.size() > 0) begin
      e = sb.pop_front();
      n_fired++;
    end
    if (acc) sb.push_back(model_decode(code));
    if (clr) begin
      m_corr   = 0;
      m_uncorr = 0;
    end else if (fire) begin
      if (e.corr && m_corr < CNT_MAX) m_corr++;
      if (e.uncorr && m_uncorr < CNT_MAX) m_uncorr++;
    end
    check("in_flight_le_2", 32'(sb.size() <= 2), 1);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #1;
    check("rst_in_ready_low", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_syn", 32'(out_syndrome), 0);
    check("rst_out_flags", 32'({out_corr, out_uncorr}), 0);
    check("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 0);
    check("rst_in_ready_held", 32'(in_ready), 0);
    sb.delete();
    m_corr   = 0;
    m_uncorr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  // Send one word into an empty pipe with no backpressure and return what appears 2 cycles later.
  task automatic send_single(input logic [CODE_W-1:0] code, input string tag, output obs_t o);
    obs_t t;
    cycle(1'b1, code, 1'b1, 1'b0, t);
    check({tag, "_accept"}, 32'(t.rdy), 1);
    cycle(1'b0, '0, 1'b1, 1'b0, t);
    check({tag, "_lat1"}, 32'(t.valid), 0);
    cycle(1'b0, '0, 1'b1, 1'b0, o);
    check({tag, "_lat2"}, 32'(o.valid), 1);
  endtask

  initial begin
    obs_t o;
    int   base;
    logic [CODE_W-1:0] c;
    logic [CODE_W-1:0] fl;
    int   b1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Data 4'hB encodes to 8'hAA under this layout.
    send_single(8'hAA, "clean", o);
    check("clean_data", 32'(o.data), 11);
    check("clean_syn", 32'(o.syn), 0);
    check("clean_flags", 32'({o.corr, o.uncorr}), 0);

    send_single(8'h8A, "bit5", o);
    check("bit5_data", 32'(o.data), 11);
    check("bit5_syn", 32'(o.syn), 5);
    check("bit5_corr", 32'(o.corr), 1);
    cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("bit5_corr_cnt", 32'(corr_cnt), 1);

    send_single(8'hCA, "bit56", o);
    check("bit56_data_raw", 32'(o.data), 13);
    check("bit56_syn", 32'(o.syn), 3);
    check("bit56_flags", 32'({o.corr, o.uncorr}), 1);
    cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("bit56_uncorr_cnt", 32'(uncorr_cnt), 1);

    send_single(8'hAB, "bit0", o);
    check("bit0_data", 32'(o.data), 11);
    check("bit0_syn", 32'(o.syn), 0);
    check("bit0_corr", 32'(o.corr), 1);

    // Backpressure: two words fill the pipe, the third waits until the sink drains.
    base = n_fired;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, o);
    check("bp_acc1", 32'(o.rdy), 1);
    cycle(1'b1, 8'h8A, 1'b0, 1'b0, o);
    check("bp_acc2", 32'(o.rdy), 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'hCA, 1'b0, 1'b0, o);
      check("bp_in_ready_low", 32'(o.rdy), 0);
      check("bp_hold_valid", 32'(o.valid), 1);
      check("bp_hold_data", 32'(o.data), 11);
    end
    cycle(1'b1, 8'hCA, 1'b1, 1'b0, o);
    check("bp_acc3", 32'(o.rdy), 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("bp_delivered", n_fired - base, 3);
    check("bp_drained", sb.size(), 0);

    // Counter saturation and clear priority.
    cycle(1'b0, '0, 1'b1, 1'b1, o);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h8A, 1'b1, 1'b0, o);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("corr_cnt_sat", 32'(corr_cnt), 3);
    cycle(1'b1, 8'h8A, 1'b1, 1'b0, o);
    cycle(1'b0, '0, 1'b1, 1'b0, o);
    cycle(1'b0, '0, 1'b1, 1'b1, o);
    check("clr_fire_valid", 32'(o.valid && o.corr), 1);
    cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("clr_priority", 32'(corr_cnt), 0);

    // Reset with two words in flight: they must vanish.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, o);
    cycle(1'b1, 8'h8A, 1'b0, 1'b0, o);
    check("rst_flight_full", sb.size(), 2);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, o);
      check("post_rst_no_out", 32'(o.valid), 0);
    end

    // Random traffic with 0, 1 or 2 flipped bits and random backpressure.
    for (int i = 0; i < 400; i++) begin
      c  = model_encode(DATA_W'($urandom));
      fl = '0;
      b1 = $urandom_range(0, CODE_W - 1);
      case ($urandom_range(0, 2))
        1: fl = CODE_W'(1) << b1;
        2: fl = (CODE_W'(1) << b1) | (CODE_W'(1) << ((b1 + $urandom_range(1, CODE_W - 1)) % CODE_W));
        default: fl = '0;
      endcase
      cycle(1'($urandom_range(0, 3) != 0), c ^ fl, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 39) == 0), o);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, o);
    check("rand_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
